// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RISC-V datapath (lw, sw, R-type, beq).
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives the datapath selects and enables, and traps on unsupported opcodes
// or on a memory access that waits too long.
module multicycle_control #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       pcSource,
    output logic       illegal,
    output logic       busErr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9,
        S_BUSERR    = 4'd10
    } state_t;

    localparam logic [6:0]        OP_LW    = 7'b0000011;
    localparam logic [6:0]        OP_SW    = 7'b0100011;
    localparam logic [6:0]        OP_R     = 7'b0110011;
    localparam logic [6:0]        OP_BEQ   = 7'b1100011;
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_LIMIT);

    state_t            state_r;
    state_t            next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              illegal_r;
    logic              buserr_r;
    logic              mem_state_s;
    logic              wait_at_limit_s;

    assign mem_state_s     = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                             (state_r == S_MEM_WRITE);
    assign wait_at_limit_s = (wait_cnt_r == WAIT_LIM);

    // Next-state selection; memReady only matters in the three memory states.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (memReady) begin
                    next_s = S_DECODE;
                end else if (wait_at_limit_s) begin
                    next_s = S_BUSERR;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_s = S_MEM_ADDR;
                    OP_R:         next_s = S_EXECUTE;
                    OP_BEQ:       next_s = S_BRANCH;
                    default:      next_s = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                // opcode is held stable, so anything but lw/sw here is corruption.
                if (opcode == OP_LW) begin
                    next_s = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    next_s = S_MEM_WRITE;
                end else begin
                    next_s = S_TRAP;
                end
            end
            S_MEM_READ: begin
                if (memReady) begin
                    next_s = S_MEM_WB;
                end else if (wait_at_limit_s) begin
                    next_s = S_BUSERR;
                end else begin
                    next_s = S_MEM_READ;
                end
            end
            S_MEM_WRITE: begin
                if (memReady) begin
                    next_s = S_FETCH;
                end else if (wait_at_limit_s) begin
                    next_s = S_BUSERR;
                end else begin
                    next_s = S_MEM_WRITE;
                end
            end
            S_MEM_WB:  next_s = S_FETCH;
            S_EXECUTE: next_s = S_R_WB;
            S_R_WB:    next_s = S_FETCH;
            S_BRANCH:  next_s = S_FETCH;
            S_TRAP:    next_s = S_TRAP;
            S_BUSERR:  next_s = S_BUSERR;
            default:   next_s = S_TRAP;
        endcase
    end

    // State register; reset lands in FETCH even mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Wait counter: restarts on every state change, counts stalled memory cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (next_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (mem_state_s && !memReady && (wait_cnt_r != WAIT_MAX)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky error flags, set on the edge that enters the error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
            buserr_r  <= 1'b0;
        end else begin
            illegal_r <= illegal_r | (next_s == S_TRAP);
            buserr_r  <= buserr_r  | (next_s == S_BUSERR);
        end
    end

    // Datapath controls decoded from state; only FETCH's IR/PC load looks at memReady.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 1'b0;
        case (state_r)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE: begin
                aluSrcB = 2'b10;
            end
            S_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_R_WB: begin
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 1'b1;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase
    end

    assign illegal = illegal_r;
    assign busErr  = buserr_r;
    assign state   = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a directed vector table, hand
// sequences for trap / bus-error / async-reset corners, and random stimulus
// against an instruction-path reference model.
module tb_multicycle_control;

    localparam int LIM = 4;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] ILL = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regWrite, aluSrcA, pcSource, illegal, busErr;
    logic [1:0] aluSrcB, aluOp;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.WAIT_LIMIT(LIM), .WAIT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
        .illegal(illegal), .busErr(busErr), .state(state)
    );

    always #5 clk = ~clk;

    // {ctl14, illegal, busErr, state}
    logic [19:0] act_s;
    assign act_s = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                    regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegal, busErr, state};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Control word per state: pcWrite pcWriteCond iorD memRead memWrite irWrite
    // memToReg regWrite aluSrcA aluSrcB[2] aluOp[2] pcSource
    logic [13:0] ctl_tab [0:15];

    function automatic logic [13:0] ctl_of(input int st, input logic rdy);
        logic [13:0] c;
        c = ctl_tab[st];
        if (st == 0 && rdy) c = c | 14'b10000100000000;
        return c;
    endfunction

    // Reference model: the instruction's state path plus a stall count.
    int m_st, m_pos, m_plen, m_wait;
    int m_path [5];
    bit m_ill, m_be;

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_wait = 0; m_ill = 1'b0; m_be = 1'b0;
        m_path = '{0, 1, 9, 0, 0}; m_plen = 3;
    endtask

    task automatic load_path(input logic [6:0] op);
        case (op)
            LW:      begin m_path = '{0, 1, 2, 3, 4}; m_plen = 5; end
            SW:      begin m_path = '{0, 1, 2, 5, 0}; m_plen = 4; end
            RT:      begin m_path = '{0, 1, 6, 7, 0}; m_plen = 4; end
            BEQ:     begin m_path = '{0, 1, 8, 0, 0}; m_plen = 3; end
            default: begin m_path = '{0, 1, 9, 0, 0}; m_plen = 3; end
        endcase
    endtask

    task automatic model_step(input logic rdy, input logic [6:0] op);
        if (m_st == 9 || m_st == 10) return;
        if ((m_st == 0 || m_st == 3 || m_st == 5) && !rdy) begin
            if (m_wait == LIM) begin
                m_st = 10; m_be = 1'b1; m_wait = 0;
            end else begin
                m_wait++;
            end
        end else begin
            if (m_pos == 1) load_path(op);
            m_pos++;
            if (m_pos >= m_plen) m_pos = 0;
            m_st = m_path[m_pos];
            m_wait = 0;
            if (m_st == 9) m_ill = 1'b1;
        end
    endtask

    // Hold reset across one rising edge; leaves time at posedge+1 in FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [6:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [1:0] aop;
        logic       rw, m2r, mw, iord, pcw, pcwc;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] op, input logic rdy, input logic [3:0] st,
                                input logic [1:0] aop, input logic rw, input logic m2r,
                                input logic mw, input logic iord, input logic pcw,
                                input logic pcwc);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.aop = aop; v.rw = rw; v.m2r = m2r;
        v.mw = mw; v.iord = iord; v.pcw = pcw; v.pcwc = pcwc;
        return v;
    endfunction

    vec_t tab [20];

    initial begin
        int stuck;
        logic rdy;
        logic [6:0] op;

        for (int i = 0; i < 16; i++) ctl_tab[i] = 14'b0;
        ctl_tab[0] = 14'b00010000001000;
        ctl_tab[1] = 14'b00000000010000;
        ctl_tab[2] = 14'b00000000110000;
        ctl_tab[3] = 14'b00110000000000;
        ctl_tab[4] = 14'b00000011000000;
        ctl_tab[5] = 14'b00101000000000;
        ctl_tab[6] = 14'b00000000100100;
        ctl_tab[7] = 14'b00000001000000;
        ctl_tab[8] = 14'b01000000100011;

        //             op   rdy   st    aop    rw    m2r   mw    iord  pcw   pcwc
        tab[0]  = mk(LW,  1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tab[1]  = mk(LW,  1'b1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[2]  = mk(LW,  1'b1, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[3]  = mk(LW,  1'b1, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tab[4]  = mk(LW,  1'b1, 4'd4, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[5]  = mk(RT,  1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tab[6]  = mk(RT,  1'b1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[7]  = mk(RT,  1'b1, 4'd6, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[8]  = mk(RT,  1'b1, 4'd7, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[9]  = mk(BEQ, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tab[10] = mk(BEQ, 1'b1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[11] = mk(BEQ, 1'b1, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tab[12] = mk(SW,  1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tab[13] = mk(SW,  1'b1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[14] = mk(SW,  1'b1, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tab[15] = mk(SW,  1'b0, 4'd5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[16] = mk(SW,  1'b0, 4'd5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[17] = mk(SW,  1'b0, 4'd5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[18] = mk(SW,  1'b1, 4'd5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tab[19] = mk(SW,  1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state: FETCH with memReady low.
        memReady = 1'b0;
        #2;
        do_reset();
        #2;
        chk("reset_outputs", 32'(act_s), 32'({14'b00010000001000, 1'b0, 1'b0, 4'd0}));

        // Directed vector table: lw, R-type, beq, sw with three stall cycles.
        for (int i = 0; i < 20; i++) begin
            opcode = tab[i].op; memReady = tab[i].rdy;
            #2;
            chk($sformatf("vec%0d", i),
                32'({state, aluOp, regWrite, memToReg, memWrite, iorD, pcWrite, pcWriteCond}),
                32'({tab[i].st, tab[i].aop, tab[i].rw, tab[i].m2r, tab[i].mw, tab[i].iord,
                     tab[i].pcw, tab[i].pcwc}));
            @(posedge clk); #1;
        end

        // Unsupported opcode traps and stays trapped; async reset clears it.
        do_reset();
        opcode = ILL; memReady = 1'b1;
        #2; chk("trap_fetch", 32'(state), 32'd0);
        @(posedge clk); #3; chk("trap_decode", 32'(state), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            memReady = i[0];
            #2;
            chk($sformatf("trap_hold%0d", i), 32'(act_s), 32'({14'b0, 1'b1, 1'b0, 4'd9}));
            @(posedge clk); #1;
        end
        #2; rst_n = 1'b0; #1;
        chk("trap_async_rst", 32'({illegal, state}), 32'({1'b0, 4'd0}));
        @(posedge clk); #1; rst_n = 1'b1;

        // memReady stuck low in FETCH: bus error after LIM+1 FETCH cycles.
        do_reset();
        memReady = 1'b0;
        for (int i = 0; i < LIM + 1; i++) begin
            #2; chk($sformatf("buserr_wait%0d", i), 32'({busErr, state}), 32'({1'b0, 4'd0}));
            @(posedge clk); #1;
        end
        #2; chk("buserr_entry", 32'(act_s), 32'({14'b0, 1'b0, 1'b1, 4'd10}));
        memReady = 1'b1;
        @(posedge clk); #3; chk("buserr_hold", 32'(act_s), 32'({14'b0, 1'b0, 1'b1, 4'd10}));

        // memReady arriving on the limit cycle completes the fetch normally.
        do_reset();
        memReady = 1'b0;
        for (int i = 0; i < LIM; i++) begin
            @(posedge clk); #1;
        end
        memReady = 1'b1;
        #2; chk("limit_ready_fetch", 32'({pcWrite, irWrite, state}), 32'({1'b1, 1'b1, 4'd0}));
        @(posedge clk); #3; chk("limit_ready_decode", 32'({busErr, state}), 32'({1'b0, 4'd1}));

        // Async reset in the middle of a stalled MEM_READ.
        do_reset();
        opcode = LW; memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        memReady = 1'b0;
        @(posedge clk); #2;
        chk("memread_stall", 32'({memRead, iorD, state}), 32'({1'b1, 1'b1, 4'd3}));
        rst_n = 1'b0; #1;
        chk("memread_async_rst", 32'({memRead, iorD, state}), 32'({1'b1, 1'b0, 4'd0}));
        @(posedge clk); #1; rst_n = 1'b1;

        // Random opcodes and memReady against the reference model.
        do_reset();
        stuck = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (stuck > 3 || (cyc % 400) == 399) begin
                do_reset();
                stuck = 0;
            end
            if (m_st == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    op = LW;
                    2, 3:    op = SW;
                    4, 5:    op = RT;
                    6, 7:    op = BEQ;
                    default: op = 7'($urandom);
                endcase
                opcode = op;
            end
            rdy = ($urandom_range(0, 3) != 0);
            memReady = rdy;
            #2;
            chk($sformatf("rand%0d", cyc), 32'(act_s),
                32'({ctl_of(m_st, rdy), m_ill, m_be, 4'(m_st)}));
            model_step(rdy, opcode);
            if (m_st >= 9) stuck++;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle RISC-V datapath, sitting directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives aluOp[1:0] to the ALU control decoder, plus all datapath mux selects and write enables.
- Supported subset: lw (0000011), sw (0100011), R-type (0110011), beq (1100011). Any other opcode traps.

Parameters:
WAIT_LIMIT, 255, maximum consecutive cycles spent waiting for memReady in one memory state before a bus error is raised (1..2^WAIT_W-1).
WAIT_W, 8, width of the wait counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instruction register bits [6:0]; stable from DECODE until the next FETCH
memReady  input  1  memory completes the current access this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if ALU zero
iorD  output  1  memory address select: 0=PC, 1=ALUOut
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  instruction register load
memToReg  output  1  register writeback select: 1=MDR, 0=ALUOut
regWrite  output  1  register file write enable
aluSrcA  output  1  ALU A select: 0=PC, 1=rs1
aluSrcB  output  2  ALU B select: 00=rs2, 01=const 4, 10=immediate
aluOp  output  2  to ALU control: 00=add, 01=branch compare, 10=funct decode
pcSource  output  1  PC source: 0=ALU result, 1=ALUOut register
illegal  output  1  sticky; unsupported opcode decoded
busErr  output  1  sticky; memory wait limit exceeded
state  output  4  current state encoding, for debug

Behaviour:
- Reset: async assertion of rst_n forces state=FETCH and clears the wait counter, illegal and busErr, at any point including mid-access. Outputs take the FETCH values below with memReady=0: memRead=1, aluSrcB=01, everything else 0.
- Outputs are decoded from state only, with one exception: irWrite and pcWrite in FETCH are ANDed with memReady. Any output not listed for a state is 0.
- State encodings and behaviour:
  - 0 FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=0. If memReady: irWrite=1, pcWrite=1, next=DECODE. Otherwise hold.
  - 1 DECODE: aluSrcA=0, aluSrcB=10, aluOp=00 (branch target computed into ALUOut). Next state by opcode: lw/sw -> MEM_ADDR; R-type -> EXECUTE; beq -> BRANCH; other -> TRAP.
  - 2 MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: lw -> MEM_READ, sw -> MEM_WRITE.
  - 3 MEM_READ: memRead=1, iorD=1. If memReady -> MEM_WB, else hold.
  - 4 MEM_WB: regWrite=1, memToReg=1. Next FETCH.
  - 5 MEM_WRITE: memWrite=1, iorD=1. If memReady -> FETCH, else hold.
  - 6 EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Next R_WB.
  - 7 R_WB: regWrite=1, memToReg=0. Next FETCH.
  - 8 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=1. Next FETCH.
  - 9 TRAP: illegal=1 (latched on entry). All enables 0. Held until reset.
  - 10 BUSERR: busErr=1 (latched on entry). All enables 0. Held until reset.
  - Encodings 11-15: next=TRAP.
- Instruction latency with zero wait states: lw=5 cycles, sw=4, R-type=4, beq=3.
- Wait counter:
  - Applies in FETCH, MEM_READ and MEM_WRITE.
  - Cleared on entry to any of those states. Increments each cycle memReady=0 while in one of them.
  - If the counter equals WAIT_LIMIT and memReady=0, the next state is BUSERR.
  - memReady=1 in the same cycle the limit is reached takes priority: the access completes normally.
  - The counter saturates; it never wraps.
- memReady is ignored in states that are not memory states.

Test Plan:
- Reset with memReady=1 from power-up, IR=lw (0000011): state sequence 0,1,2,3,4,0. aluOp=00 throughout. regWrite=1 and memToReg=1 exactly in state 4.
- R-type (0110011), zero waits: states 0,1,6,7,0. aluOp=10 only in state 6. regWrite=1 with memToReg=0 in state 7.
- beq (1100011): states 0,1,8,0. In state 8: aluOp=01, pcWriteCond=1, pcSource=1, pcWrite=0.
- sw with memReady low for 3 cycles in MEM_WRITE: memWrite=1 and iorD=1 held for 4 cycles, then FETCH. No regWrite at any point.
- Opcode 0010011 at DECODE -> TRAP. illegal=1, all enables 0 for 10+ cycles. rst_n pulse returns to FETCH with illegal=0.
- WAIT_LIMIT=4, memReady held 0 in FETCH: BUSERR entered after 5 FETCH cycles, busErr=1. Repeat with memReady=1 on the 5th cycle: normal entry to DECODE. Assert rst_n=0 mid-MEM_READ: state=0 and memRead/iorD take their reset values without waiting for a clock edge.
